// File: rtl/downscale_pkg.sv
// Shared types for the SIMD downscaler writeback stage: state encoding,
// pixel type and the pixel-counter width helper.
package downscale_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_DRAIN,
        ST_DONE
    } wb_state_t;

    typedef logic [7:0] pixel_t;

    // One extra bit so the counter can hold TOTAL itself, not just TOTAL-1.
    function automatic int count_width(input int total);
        return $clog2(total) + 1;
    endfunction

endpackage

// File: rtl/downscale_writeback_simd_if.sv
// Vector input stream plus byte-wide BRAM write port of the writeback stage.
// The slave side is the writeback block; the master side feeds it and observes the memory port.
interface downscale_writeback_simd_if #(
    parameter int N      = 4,
    parameter int ADDR_W = 16
);
    import downscale_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [N*8-1:0]    in_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    pixel_t            mem_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_data
    );

endinterface

// File: rtl/downscale_writeback_simd_lane_serializer.sv
// Holds one N-lane pixel vector and steps through its lanes one per cycle,
// lane 0 first.
module lane_serializer
    import downscale_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           advance,
    input  logic [N*8-1:0] vec,
    output pixel_t         lane_data,
    output logic           last
);

    localparam int LANE_W = (N > 1) ? $clog2(N) : 1;

    pixel_t            hold [N];
    logic [LANE_W-1:0] lane;

    // A load wins over an advance so a back-to-back vector restarts at lane 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= '0;
            for (int k = 0; k < N; k++) begin
                hold[k] <= '0;
            end
        end else if (load) begin
            lane <= '0;
            for (int k = 0; k < N; k++) begin
                hold[k] <= vec[8*k +: 8];
            end
        end else if (advance) begin
            lane <= lane + LANE_W'(1);
        end
    end

    assign lane_data = hold[lane];
    assign last      = (lane == LANE_W'(N - 1));

endmodule

// File: rtl/downscale_writeback_simd.sv
// Writeback stage: accepts N-lane pixel vectors and serializes them to a
// byte-wide BRAM port at consecutive addresses from a latched base.
module downscale_writeback_simd
    import downscale_pkg::*;
#(
    parameter int DST_W  = 16,
    parameter int DST_H  = 16,
    parameter int N      = 4,
    parameter int ADDR_W = 16
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [ADDR_W-1:0]                       base_addr,
    downscale_writeback_simd_if.slave               bus,
    output logic                                    busy,
    output logic                                    done,
    output logic [count_width(DST_W*DST_H)-1:0]     pix_count
);

    localparam int TOTAL = DST_W * DST_H;
    localparam int CNT_W = count_width(TOTAL);

    wb_state_t         state;
    wb_state_t         state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    pixel_t            data_q;
    pixel_t            lane_data;
    logic [ADDR_W-1:0] write_addr;
    logic              load;
    logic              advance;
    logic              lane_last;
    logic              frame_last;
    logic              write_en;
    logic              ready;

    lane_serializer #(.N(N)) u_serializer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .vec       (bus.in_data),
        .lane_data (lane_data),
        .last      (lane_last)
    );

    assign write_addr = base_q + ADDR_W'(pix_count);
    assign frame_last = (pix_count == CNT_W'(TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Leaving DRAIN on the TOTAL-th pixel is what discards the unused lanes
    // of a partial final vector.
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        advance  = 1'b0;
        ready    = 1'b0;
        write_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_ACCEPT;
                end
            end
            ST_ACCEPT: begin
                ready = 1'b1;
                if (bus.in_valid) begin
                    load     = 1'b1;
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                write_en = (pix_count < CNT_W'(TOTAL));
                if (frame_last) begin
                    state_nx = ST_DONE;
                end else if (lane_last) begin
                    ready = 1'b1;
                    if (bus.in_valid) begin
                        load = 1'b1;
                    end else begin
                        state_nx = ST_ACCEPT;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // addr_q/data_q remember the last write so the port holds steady between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            pix_count <= '0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            if (state == ST_IDLE && start) begin
                base_q    <= base_addr;
                pix_count <= '0;
            end
            if (write_en) begin
                pix_count <= pix_count + CNT_W'(1);
                addr_q    <= write_addr;
                data_q    <= lane_data;
            end
        end
    end

    assign bus.in_ready = ready;
    assign bus.mem_we   = write_en;
    assign bus.mem_addr = write_en ? write_addr : addr_q;
    assign bus.mem_data = write_en ? lane_data : data_q;
    assign busy         = (state == ST_ACCEPT) || (state == ST_DRAIN);
    assign done         = (state == ST_DONE);

endmodule

// File: tb/tb_downscale_writeback_simd.sv
// Directed bench: a 4x4 and a 3x3 writeback instance share one N=4 vector
// stream; every BRAM write of both is logged and compared to pixel index order.
module tb_downscale_writeback_simd;
    import downscale_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] base_addr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        busy_a, done_a, busy_b, done_b;
    logic [4:0]  pc_a, pc_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    downscale_writeback_simd_if #(.N(4), .ADDR_W(16)) bus_a ();
    downscale_writeback_simd_if #(.N(4), .ADDR_W(16)) bus_b ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.in_data  = in_data;
    assign bus_b.in_valid = in_valid;
    assign bus_b.in_data  = in_data;

    downscale_writeback_simd #(.DST_W(4), .DST_H(4), .N(4), .ADDR_W(16)) dut_a (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus_a),
        .busy(busy_a), .done(done_a), .pix_count(pc_a)
    );

    downscale_writeback_simd #(.DST_W(3), .DST_H(3), .N(4), .ADDR_W(16)) dut_b (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .bus(bus_b),
        .busy(busy_b), .done(done_b), .pix_count(pc_b)
    );

    always #5 clk = ~clk;

    // Write log per instance: 0 = 4x4, 1 = 3x3.
    logic        we_v [2];
    logic        rdy_v [2];
    logic        dn_v [2];
    logic [15:0] ad_v [2];
    logic [7:0]  dt_v [2];
    logic [4:0]  pc_v [2];

    assign we_v[0] = bus_a.mem_we;   assign we_v[1] = bus_b.mem_we;
    assign rdy_v[0] = bus_a.in_ready; assign rdy_v[1] = bus_b.in_ready;
    assign dn_v[0] = done_a;         assign dn_v[1] = done_b;
    assign ad_v[0] = bus_a.mem_addr; assign ad_v[1] = bus_b.mem_addr;
    assign dt_v[0] = bus_a.mem_data; assign dt_v[1] = bus_b.mem_data;
    assign pc_v[0] = pc_a;           assign pc_v[1] = pc_b;

    int          wn [2];
    int          rdy_n [2];
    int          done_cyc [2];
    logic [15:0] wa [2][64];
    logic [7:0]  wd [2][64];
    int          wp [2][64];
    int          wc [2][64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (we_v[d] && wn[d] < 64) begin
                wa[d][wn[d]] <= ad_v[d];
                wd[d][wn[d]] <= dt_v[d];
                wp[d][wn[d]] <= int'(pc_v[d]);
                wc[d][wn[d]] <= cyc;
                wn[d]        <= wn[d] + 1;
            end
            if (rdy_v[d]) rdy_n[d] <= rdy_n[d] + 1;
            if (dn_v[d] && done_cyc[d] < 0) done_cyc[d] <= cyc;
        end
    end

    task automatic clear_mon();
        for (int d = 0; d < 2; d++) begin
            wn[d] = 0;
            rdy_n[d] = 0;
            done_cyc[d] = -1;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] vec(input int v);
        return {8'(4*v + 3), 8'(4*v + 2), 8'(4*v + 1), 8'(4*v)};
    endfunction

    task automatic check_all_zero(input string tag);
        check_output({tag, "_in_ready"}, 32'(bus_a.in_ready), 0);
        check_output({tag, "_mem_we"},   32'(bus_a.mem_we), 0);
        check_output({tag, "_mem_addr"}, 32'(bus_a.mem_addr), 0);
        check_output({tag, "_mem_data"}, 32'(bus_a.mem_data), 0);
        check_output({tag, "_busy"},     32'(busy_a), 0);
        check_output({tag, "_done"},     32'(done_a), 0);
        check_output({tag, "_pix_count"}, 32'(pc_a), 0);
        check_output({tag, "_b_busy"},   32'(busy_b), 0);
        check_output({tag, "_b_pix_count"}, 32'(pc_b), 0);
    endtask

    // Starts a frame and offers four vectors (pixel indices 0..15); returns in the first done cycle of the 4x4 instance.
    task automatic apply_stimulus(input logic [15:0] base, input int gap, input bit hold_start);
        int t;
        start = 1'b1;
        base_addr = base;
        for (int v = 0; v < 4; v++) begin
            in_valid = 1'b1;
            in_data = vec(v);
            t = 0;
            while (!bus_a.in_ready && t < 40) begin
                tick();
                t++;
            end
            if (t >= 40) begin
                check_output("ready_timeout", 32'(t), 0);
                in_valid = 1'b0;
                start = 1'b0;
                return;
            end
            tick();
            if (!hold_start) start = 1'b0;
            if (gap > 0 && v < 3) begin
                in_valid = 1'b0;
                repeat (4) tick();
                for (int g = 0; g < gap; g++) begin
                    check_output($sformatf("gap%0d_busy", g), 32'(busy_a), 1);
                    check_output($sformatf("gap%0d_ready", g), 32'(bus_a.in_ready), 1);
                    check_output($sformatf("gap%0d_we", g), 32'(bus_a.mem_we), 0);
                    tick();
                end
            end
        end
        in_valid = 1'b0;
        t = 0;
        while (!done_a && t < 60) begin
            tick();
            t++;
        end
        if (t >= 60) check_output("done_timeout", 32'(t), 0);
    endtask

    task automatic check_frame(input int d, input int total, input logic [15:0] base, input bit contiguous);
        string p;
        p = (d == 0) ? "a" : "b";
        check_output({p, "_write_count"}, 32'(wn[d]), 32'(total));
        for (int i = 0; i < total && i < wn[d]; i++) begin
            check_output($sformatf("%s_addr%0d", p, i), 32'(wa[d][i]), 32'(16'(base + 16'(i))));
            check_output($sformatf("%s_data%0d", p, i), 32'(wd[d][i]), 32'(8'(i)));
            check_output($sformatf("%s_pc%0d", p, i), 32'(wp[d][i]), 32'(i));
            if (contiguous) check_output($sformatf("%s_cycle%0d", p, i), 32'(wc[d][i]), 32'(wc[d][0] + i));
        end
        if (wn[d] > 0) check_output({p, "_done_cycle"}, 32'(done_cyc[d]), 32'(wc[d][wn[d]-1] + 1));
        check_output({p, "_pix_count_end"}, 32'(pc_v[d]), 32'(total));
    endtask

    initial begin
        int t;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        in_valid = 1'b0;
        in_data = '0;
        clear_mon();
        repeat (2) tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        $display("[TB] vectors offered in IDLE are not taken");
        in_valid = 1'b1;
        in_data = vec(7);
        repeat (2) tick();
        check_output("idle_ready", 32'(bus_a.in_ready), 0);
        check_output("idle_we", 32'(bus_a.mem_we), 0);
        in_valid = 1'b0;
        tick();

        $display("[TB] basic frame, base 1024, back-to-back vectors");
        clear_mon();
        apply_stimulus(16'd1024, 0, 1'b0);
        check_frame(0, 16, 16'd1024, 1'b1);
        check_frame(1, 9, 16'd1024, 1'b1);
        check_output("a_ready_cycles", 32'(rdy_n[0]), 4);
        check_output("b_ready_cycles", 32'(rdy_n[1]), 3);
        tick();
        check_output("done_drop", 32'(done_a), 0);
        check_output("hold_addr", 32'(bus_a.mem_addr), 32'd1039);
        check_output("hold_data", 32'(bus_a.mem_data), 32'd15);
        tick();

        $display("[TB] backpressure gaps of 3 cycles");
        clear_mon();
        apply_stimulus(16'd200, 3, 1'b0);
        check_frame(0, 16, 16'd200, 1'b0);
        check_frame(1, 9, 16'd200, 1'b0);
        repeat (2) tick();

        $display("[TB] address wrap from FFFE");
        clear_mon();
        apply_stimulus(16'hFFFE, 0, 1'b0);
        check_frame(0, 16, 16'hFFFE, 1'b1);
        repeat (2) tick();

        $display("[TB] start held through the frame and after done");
        clear_mon();
        apply_stimulus(16'd100, 0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("done_hold%0d", k), 32'(done_a), 1);
            if (k == 4) start = 1'b0;
            tick();
        end
        check_output("done_fall", 32'(done_a), 0);
        check_output("done_fall_busy", 32'(busy_a), 0);
        check_frame(0, 16, 16'd100, 1'b1);
        tick();

        $display("[TB] reset in the middle of a frame");
        clear_mon();
        start = 1'b1;
        base_addr = 16'd500;
        in_valid = 1'b1;
        in_data = vec(0);
        t = 0;
        while (!bus_a.in_ready && t < 40) begin
            tick();
            t++;
        end
        tick();
        start = 1'b0;
        in_data = vec(1);
        t = 0;
        while (wn[0] < 6 && t < 40) begin
            tick();
            t++;
        end
        check_output("six_writes", 32'(wn[0]), 6);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        tick();
        rst = 1'b0;
        tick();
        check_output("after_reset_pc", 32'(pc_a), 0);
        clear_mon();
        apply_stimulus(16'd0, 0, 1'b0);
        check_frame(0, 16, 16'd0, 1'b1);
        check_frame(1, 9, 16'd0, 1'b1);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/downscale_writeback_simd.md
Name: downscale_writeback_simd

Overview:
- Downstream stage of the SIMD downscaler.
- Accepts downscaled pixels as N-lane vectors over a valid/ready handshake and serializes them onto the single byte-wide BRAM write port.
- Writes DST_W*DST_H pixels to consecutive addresses starting at a base latched at start, then raises done.
- Fills the result-writeback step of the downscale top level; the result region is normally base = SRC_W*SRC_H.

Parameters:
- DST_W, 16: destination image width in pixels.
- DST_H, 16: destination image height in pixels.
- N, 4: lanes per input vector.
- ADDR_W, 16: BRAM write address width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level request; sampled in IDLE.
- base_addr  input  ADDR_W  first write address; latched when start is accepted.
- in_valid  input  1  input vector valid.
- in_ready  output  1  block can accept a vector this cycle.
- in_data  input  N*8  packed vector; lane k is bits [8k+7:8k]; lane 0 is the lowest pixel index.
- mem_we  output  1  BRAM write strobe.
- mem_addr  output  ADDR_W  BRAM write address.
- mem_data  output  8  BRAM write data.
- busy  output  1  high in ACCEPT or DRAIN.
- done  output  1  high in DONE.
- pix_count  output  $clog2(DST_W*DST_H)+1  pixels written so far in the current frame.

Behaviour:
- Constant TOTAL = DST_W*DST_H.
- Reset (asynchronous, at any time, including mid-frame): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, pix_count=0; the holding register and lane counter are cleared. Any partial frame is abandoned.
- IDLE:
  - in_ready=0; vectors offered here are neither accepted nor dropped.
  - If start=1: latch base_addr, clear pix_count, go to ACCEPT.
- ACCEPT:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data into the holding register, set lane=0, go to DRAIN.
- DRAIN: one lane written per cycle.
  - mem_we=1, mem_addr=(base+pix_count) mod 2^ADDR_W (silent wrap), mem_data=hold[lane].
  - pix_count and lane increment each cycle.
  - Last-vector masking: a lane is written only while pix_count<TOTAL. If TOTAL mod N != 0, the remaining lanes of the final vector are discarded with no write.
  - End of frame: when the written pixel is the TOTAL-th, go to DONE.
  - End of vector: when lane==N-1 and the frame is not complete, in_ready=1 in that same cycle.
    - If in_valid=1, capture the next vector and stay in DRAIN with lane=0 (back-to-back, no bubble).
    - Otherwise go to ACCEPT.
- Throughput: one pixel per cycle sustained.
- Latency: vector accepted at edge t → lane k write presented in cycle t+1+k.
- DONE:
  - done=1, in_ready=0, mem_we=0.
  - Stays in DONE while start=1. When start=0, go to IDLE; done drops the following cycle.
- start in ACCEPT or DRAIN is ignored; no restart without passing through DONE→IDLE.
- mem_we is asserted only in DRAIN on valid lanes. mem_addr and mem_data hold their last values when mem_we=0.
- TOTAL=0 is not supported.

Decomposition:
- Shared package (downscale_pkg) holds:
  - the state enum for this block (IDLE, ACCEPT, DRAIN, DONE);
  - the pixel typedef (logic [7:0]);
  - a function for the pixel-count width.
- One natural sub-module, lane_serializer: holding register plus lane counter with load/advance/last outputs. The top contains the FSM and address/count logic.

Test Plan:
- Basic frame:
  - Stimulus: DST=4x4, N=4, base=1024; start; 4 vectors with in_valid always 1, lanes = pixel index.
  - Required: 16 writes on consecutive cycles to addresses 1024..1039, data 0..15.
  - Required: in_ready low except the acceptance cycles; done 1 cycle after the last write; pix_count=16.
- Partial last vector:
  - Stimulus: DST=3x3, N=4.
  - Required: exactly 9 writes; lanes 1..3 of the third vector are never written; done follows write 9.
- Backpressure gaps:
  - Stimulus: in_valid deasserted for 3 cycles between vectors.
  - Required: state ACCEPT during the gap, mem_we=0, no duplicated or missing addresses.
- Address wrap:
  - Stimulus: ADDR_W=16, base=16'hFFFE, 4x4.
  - Required: addresses FFFE, FFFF, 0000 ... 000D.
- Reset mid-frame:
  - Stimulus: assert rst after 6 writes, then release and run a new frame with base=0.
  - Required: all outputs 0 immediately on reset; the new frame starts at address 0 with pix_count restarting at 0.
- Done/start handshake:
  - Stimulus: hold start=1 for 5 cycles after done, then drop it.
  - Required: done stays 1 for those 5 cycles and falls one cycle after start=0; start asserted during DRAIN has no effect.
